// File: rtl/reg_file_sync_read.sv
// Register file with one write port and two registered read ports (A/B).
// Same-cycle write data is forwarded into the read registers.
module reg_file_sync_read #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int ZERO_REG   = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  write,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   input  logic                  hold,
   input  logic [ADDR_WIDTH-1:0] ra_addr,
   input  logic [ADDR_WIDTH-1:0] rb_addr,
   output logic [DATA_WIDTH-1:0] ra_data,
   output logic [DATA_WIDTH-1:0] rb_data,
   output logic                  rd_valid
);

   localparam int DEPTH = 2**ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] regs [DEPTH];
   logic [DATA_WIDTH-1:0] ra_next;
   logic [DATA_WIDTH-1:0] rb_next;
   logic                  wr_en;

   assign wr_en = write && !((ZERO_REG != 0) && (wr_addr == '0));

   // Zero-register check wins over forwarding so r0 never shows stray write data.
   always_comb begin
      ra_next = regs[ra_addr];
      if (write && (wr_addr == ra_addr)) ra_next = wr_data;
      if ((ZERO_REG != 0) && (ra_addr == '0)) ra_next = '0;

      rb_next = regs[rb_addr];
      if (write && (wr_addr == rb_addr)) rb_next = wr_data;
      if ((ZERO_REG != 0) && (rb_addr == '0)) rb_next = '0;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      end else if (wr_en) begin
         regs[wr_addr] <= wr_data;
      end
   end

   // Stores keep going during a stall; only the read registers freeze.
   always_ff @(posedge clk) begin
      if (!reset) begin
         ra_data  <= '0;
         rb_data  <= '0;
         rd_valid <= 1'b0;
      end else if (!hold) begin
         if (rd_en) begin
            ra_data  <= ra_next;
            rb_data  <= rb_next;
            rd_valid <= 1'b1;
         end else begin
            rd_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_reg_file_sync_read.sv
// Directed vector bench for reg_file_sync_read; a second instance with
// ZERO_REG=0 shares all inputs to contrast register-0 behaviour.
module tb_reg_file_sync_read;

   logic        clk;
   logic        reset;
   logic        write;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;
   logic        rd_en;
   logic        hold;
   logic [4:0]  ra_addr;
   logic [4:0]  rb_addr;
   logic [31:0] ra_data, rb_data, ra_data_nz, rb_data_nz;
   logic        rd_valid, rd_valid_nz;

   int checks = 0;
   int errors = 0;

   reg_file_sync_read #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(1)) dut (
      .clk(clk), .reset(reset), .write(write), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_en(rd_en), .hold(hold), .ra_addr(ra_addr), .rb_addr(rb_addr),
      .ra_data(ra_data), .rb_data(rb_data), .rd_valid(rd_valid)
   );

   reg_file_sync_read #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(0)) dut_nz (
      .clk(clk), .reset(reset), .write(write), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_en(rd_en), .hold(hold), .ra_addr(ra_addr), .rb_addr(rb_addr),
      .ra_data(ra_data_nz), .rb_data(rb_data_nz), .rd_valid(rd_valid_nz)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        wr;
      logic [4:0]  wa;
      logic [31:0] wd;
      logic        re;
      logic        hd;
      logic [4:0]  ra;
      logic [4:0]  rb;
      logic [31:0] er;
      logic [31:0] eb;
      logic        ev;
   } vec_t;

   localparam int NVEC = 18;
   vec_t vecs [NVEC];

   function automatic vec_t mk(logic rst, logic wr, logic [4:0] wa, logic [31:0] wd,
                               logic re, logic hd, logic [4:0] ra, logic [4:0] rb,
                               logic [31:0] er, logic [31:0] eb, logic ev);
      vec_t v;
      v.rst = rst; v.wr = wr; v.wa = wa; v.wd = wd; v.re = re; v.hd = hd;
      v.ra = ra; v.rb = rb; v.er = er; v.eb = eb; v.ev = ev;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic rst, input logic wr, input logic [4:0] wa,
                        input logic [31:0] wd, input logic re, input logic hd,
                        input logic [4:0] ra, input logic [4:0] rb);
      reset = rst; write = wr; wr_addr = wa; wr_data = wd;
      rd_en = re; hold = hd; ra_addr = ra; rb_addr = rb;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [31:0] held_a, held_b;

      // rst wr wa wd re hd ra rb | exp_ra exp_rb exp_valid
      vecs[0]  = mk(0,0,0,32'h0,        0,0,0,0, 32'h0,        32'h0,        0);
      vecs[1]  = mk(1,1,5,32'hDEADBEEF, 0,0,0,0, 32'h0,        32'h0,        0);
      vecs[2]  = mk(0,0,0,32'h0,        1,0,5,5, 32'h0,        32'h0,        0);
      vecs[3]  = mk(0,1,5,32'h11111111, 1,0,5,5, 32'h0,        32'h0,        0);
      vecs[4]  = mk(1,0,0,32'h0,        1,0,5,5, 32'h0,        32'h0,        1);
      vecs[5]  = mk(1,1,3,32'h12345678, 0,0,0,0, 32'h0,        32'h0,        0);
      vecs[6]  = mk(1,0,0,32'h0,        1,0,3,0, 32'h12345678, 32'h0,        1);
      vecs[7]  = mk(1,1,7,32'hA5A5A5A5, 1,0,7,7, 32'hA5A5A5A5, 32'hA5A5A5A5, 1);
      vecs[8]  = mk(1,0,0,32'h0,        0,0,3,3, 32'hA5A5A5A5, 32'hA5A5A5A5, 0);
      vecs[9]  = mk(1,0,0,32'h0,        1,0,3,7, 32'h12345678, 32'hA5A5A5A5, 1);
      vecs[10] = mk(1,1,3,32'h0BADF00D, 1,1,3,3, 32'h12345678, 32'hA5A5A5A5, 1);
      vecs[11] = mk(1,0,0,32'h0,        0,1,3,3, 32'h12345678, 32'hA5A5A5A5, 1);
      vecs[12] = mk(1,0,0,32'h0,        1,1,7,3, 32'h12345678, 32'hA5A5A5A5, 1);
      vecs[13] = mk(1,0,0,32'h0,        1,0,3,3, 32'h0BADF00D, 32'h0BADF00D, 1);
      vecs[14] = mk(1,0,0,32'h0,        0,1,0,0, 32'h0BADF00D, 32'h0BADF00D, 1);
      vecs[15] = mk(0,0,0,32'h0,        1,1,3,3, 32'h0,        32'h0,        0);
      vecs[16] = mk(1,0,0,32'h0,        1,1,3,7, 32'h0,        32'h0,        0);
      vecs[17] = mk(1,0,0,32'h0,        1,0,3,7, 32'h0,        32'h0,        1);

      drive(0, 0, 0, 0, 0, 0, 0, 0);

      // Register 0 is never written in the table, so both instances must agree.
      for (int i = 0; i < NVEC; i++) begin
         drive(vecs[i].rst, vecs[i].wr, vecs[i].wa, vecs[i].wd,
               vecs[i].re, vecs[i].hd, vecs[i].ra, vecs[i].rb);
         tick();
         chk($sformatf("v%0d ra_data", i), ra_data, vecs[i].er);
         chk($sformatf("v%0d rb_data", i), rb_data, vecs[i].eb);
         chk($sformatf("v%0d rd_valid", i), {31'b0, rd_valid}, {31'b0, vecs[i].ev});
         chk($sformatf("v%0d nz ra_data", i), ra_data_nz, vecs[i].er);
         chk($sformatf("v%0d nz rb_data", i), rb_data_nz, vecs[i].eb);
         chk($sformatf("v%0d nz rd_valid", i), {31'b0, rd_valid_nz}, {31'b0, vecs[i].ev});
      end

      // Register 0: stored write then read
      drive(1, 1, 0, 32'hFFFFFFFF, 0, 0, 0, 0);
      tick();
      drive(1, 0, 0, 32'h0, 1, 0, 0, 0);
      tick();
      chk("zero ra_data", ra_data, 32'h0);
      chk("zero rb_data", rb_data, 32'h0);
      chk("nonzero ra_data", ra_data_nz, 32'hFFFFFFFF);
      chk("nonzero rb_data", rb_data_nz, 32'hFFFFFFFF);

      // Register 0: forwarding path must also be masked
      drive(1, 1, 0, 32'h11111111, 1, 0, 0, 3);
      tick();
      chk("zero fwd ra_data", ra_data, 32'h0);
      chk("nonzero fwd ra_data", ra_data_nz, 32'h11111111);
      chk("zero fwd rb_data", rb_data, 32'h0);

      // Load a known value, then X on unused inputs while idle and stalled
      drive(1, 1, 9, 32'hCAFE0009, 1, 0, 9, 9);
      tick();
      chk("fwd r9 ra_data", ra_data, 32'hCAFE0009);
      held_a = 32'hCAFE0009;
      held_b = 32'hCAFE0009;
      drive(1, 0, 'x, 'x, 0, 0, 'x, 'x);
      tick();
      chk("idle X ra_data", ra_data, held_a);
      chk("idle X rb_data", rb_data, held_b);
      chk("idle rd_valid", {31'b0, rd_valid}, 32'h0);
      drive(1, 0, 0, 32'h0, 1, 0, 9, 3);
      tick();
      chk("r9 reread ra_data", ra_data, 32'hCAFE0009);
      drive(1, 0, 'x, 'x, 'x, 1, 'x, 'x);
      tick();
      chk("stall X ra_data", ra_data, 32'hCAFE0009);
      chk("stall X rd_valid", {31'b0, rd_valid}, 32'h1);

      // Write during stall lands in storage and appears on the next read
      drive(1, 1, 9, 32'h0000BEEF, 1, 1, 9, 9);
      tick();
      chk("stall write ra_data", ra_data, 32'hCAFE0009);
      drive(1, 0, 0, 32'h0, 1, 0, 9, 0);
      tick();
      chk("post stall ra_data", ra_data, 32'h0000BEEF);
      chk("post stall rb_data", rb_data, 32'h0);
      chk("post stall rd_valid", {31'b0, rd_valid}, 32'h1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
